// File: rtl/operand_fetch.sv
// Issue stage: decodes instructions, reads the register file, tracks pending writes and presents registered operands to the ALU.
// Optional macro OPERAND_FETCH_WB_BYPASS_EN forwards same-cycle writeback data and releases hazards in the writeback cycle.
package simple_processor_pkg;
  localparam int DATA_WIDTH = 32;

  typedef enum logic [3:0] {
    FUNC_ADD  = 4'd0,
    FUNC_SUB  = 4'd1,
    FUNC_AND  = 4'd2,
    FUNC_OR   = 4'd3,
    FUNC_XOR  = 4'd4,
    FUNC_SLL  = 4'd5,
    FUNC_SRL  = 4'd6,
    FUNC_ADDI = 4'd7
  } func_t;
endpackage

module operand_fetch
  import simple_processor_pkg::*;
#(
  parameter int NUM_REGS = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  instr_valid_i,
  output logic                  instr_ready_o,
  input  logic [31:0]           instr_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output func_t                 func_o,
  output logic [DATA_WIDTH-1:0] rs1_data_o,
  output logic [DATA_WIDTH-1:0] rs2_data_o,
  output logic [5:0]            imm_o,
  output logic [4:0]            rd_o,
  input  logic                  wb_en_i,
  input  logic [4:0]            wb_addr_i,
  input  logic [DATA_WIDTH-1:0] wb_data_i
);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0]   pending;

  func_t                 func;
  logic [4:0]            rd;
  logic [4:0]            rs1;
  logic [4:0]            rs2;
  logic [5:0]            imm;
  logic                  unused_instr_bits;

  logic                  wb_live;
  logic                  rs1_fwd;
  logic                  rs2_fwd;
  logic                  rd_fwd;
  logic                  hazard;
  logic                  fire;
  logic [DATA_WIDTH-1:0] rs1_val;
  logic [DATA_WIDTH-1:0] rs2_val;

  assign rd                = instr_i[4:0];
  assign rs1               = instr_i[9:5];
  assign rs2               = instr_i[14:10];
  assign imm               = instr_i[20:15];
  assign func              = func_t'(instr_i[31 -: $bits(func_t)]);
  assign unused_instr_bits = ^instr_i[31-$bits(func_t):21];

  assign wb_live = wb_en_i && (wb_addr_i != 5'd0);

  // x0 is never pending, so only nonzero indices can raise a hazard.
  always_comb begin
    rs1_fwd = 1'b0;
    rs2_fwd = 1'b0;
    rd_fwd  = 1'b0;
`ifdef OPERAND_FETCH_WB_BYPASS_EN
    rs1_fwd = wb_live && (wb_addr_i == rs1);
    rs2_fwd = wb_live && (wb_addr_i == rs2);
    rd_fwd  = wb_live && (wb_addr_i == rd);
`endif
    hazard = ((rs1 != 5'd0) && pending[rs1] && !rs1_fwd)
          || ((func != FUNC_ADDI) && (rs2 != 5'd0) && pending[rs2] && !rs2_fwd)
          || ((rd != 5'd0) && pending[rd] && !rd_fwd);
    rs1_val = (rs1 == 5'd0) ? '0 : (rs1_fwd ? wb_data_i : regs[rs1]);
    rs2_val = (rs2 == 5'd0) ? '0 : (rs2_fwd ? wb_data_i : regs[rs2]);
  end

  assign instr_ready_o = (!valid_o || ready_i) && !(instr_valid_i && hazard);
  assign fire          = instr_valid_i && instr_ready_o;

  // The issue-side set is placed last so it overrides a same-cycle writeback clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      pending <= '0;
    end else begin
      if (wb_live) begin
        regs[wb_addr_i]    <= wb_data_i;
        pending[wb_addr_i] <= 1'b0;
      end
      if (fire && (rd != 5'd0)) begin
        pending[rd] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_o    <= 1'b0;
      func_o     <= FUNC_ADD;
      rs1_data_o <= '0;
      rs2_data_o <= '0;
      imm_o      <= '0;
      rd_o       <= '0;
    end else if (fire) begin
      valid_o    <= 1'b1;
      func_o     <= func;
      rs1_data_o <= rs1_val;
      rs2_data_o <= rs2_val;
      imm_o      <= imm;
      rd_o       <= rd;
    end else if (ready_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch: a reference model predicts ready, hazards and operand values each cycle.
module tb_operand_fetch;
  import simple_processor_pkg::*;

  typedef struct {
    logic [3:0]  func;
    logic [4:0]  rd;
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  imm;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic        valid;
  logic        ready;
  func_t       func;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [5:0]  imm;
  logic [4:0]  rd;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  int          compare_count  = 0;
  int          mismatch_count = 0;

  logic [31:0] m_regs [32];
  logic [31:0] m_pend;
  logic        m_valid;
  bit          reset_seen;
  bit          last_fire;
  exp_t        sb[$];

  always #5 clk = ~clk;

  operand_fetch dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .instr_valid_i (instr_valid),
    .instr_ready_o (instr_ready),
    .instr_i       (instr),
    .valid_o       (valid),
    .ready_i       (ready),
    .func_o        (func),
    .rs1_data_o    (rs1_data),
    .rs2_data_o    (rs2_data),
    .imm_o         (imm),
    .rd_o          (rd),
    .wb_en_i       (wb_en),
    .wb_addr_i     (wb_addr),
    .wb_data_i     (wb_data)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compare_count++;
    if (got !== exp) begin
      mismatch_count++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input logic [3:0] f, input logic [4:0] d, input logic [4:0] s1,
                                     input logic [4:0] s2, input logic [5:0] im);
    logic [6:0] pad;
    pad = 7'($urandom);
    return {f, pad, im, s2, s1, d};
  endfunction

  function automatic bit src_haz(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
`ifdef OPERAND_FETCH_WB_BYPASS_EN
    if (wb_en && wb_addr == r) return 1'b0;
`endif
    return m_pend[r];
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
`ifdef OPERAND_FETCH_WB_BYPASS_EN
    if (wb_en && wb_addr == r) return wb_data;
`endif
    return m_regs[r];
  endfunction

  // One clock: compare at the falling edge, then advance the model past the rising edge.
  task automatic tick();
    bit   hz;
    bit   exp_ready;
    bit   fire;
    exp_t e;
    fire = 1'b0;
    @(negedge clk);
    if (rst) begin
      if (reset_seen) begin
        checkOutput("rst_valid", 32'(valid), 32'd0);
        checkOutput("rst_rd", 32'(rd), 32'd0);
        checkOutput("rst_rs1", rs1_data, 32'd0);
        checkOutput("rst_func", 32'(func), 32'd0);
      end
    end else begin
      hz = src_haz(instr[9:5]) || ((instr[31:28] != 4'(FUNC_ADDI)) && src_haz(instr[14:10]))
        || src_haz(instr[4:0]);
      exp_ready = (!m_valid || ready) && !(instr_valid && hz);
      checkOutput("instr_ready", 32'(instr_ready), 32'(exp_ready));
      checkOutput("valid", 32'(valid), 32'(m_valid));
      if (m_valid && sb.size() > 0) begin
        e = sb[0];
        checkOutput("func", 32'(func), 32'(e.func));
        checkOutput("rd", 32'(rd), 32'(e.rd));
        checkOutput("rs1_data", rs1_data, e.a);
        checkOutput("rs2_data", rs2_data, e.b);
        checkOutput("imm", 32'(imm), 32'(e.imm));
        if (ready) void'(sb.pop_front());
      end
      fire = instr_valid && exp_ready;
      if (fire) begin
        e.func = instr[31:28];
        e.rd   = instr[4:0];
        e.a    = model_read(instr[9:5]);
        e.b    = model_read(instr[14:10]);
        e.imm  = instr[20:15];
        sb.push_back(e);
      end
    end
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_pend     = '0;
      m_valid    = 1'b0;
      sb.delete();
      reset_seen = 1'b1;
    end else begin
      reset_seen = 1'b0;
      if (wb_en && wb_addr != 5'd0) begin
        m_regs[wb_addr] = wb_data;
        m_pend[wb_addr] = 1'b0;
      end
      if (fire && instr[4:0] != 5'd0) m_pend[instr[4:0]] = 1'b1;
      if (fire) m_valid = 1'b1;
      else if (ready) m_valid = 1'b0;
    end
    last_fire = fire;
    #1;
    wb_en = 1'b0;
  endtask

  // Holds an instruction until accepted, optionally pulsing a writeback wb_at cycles into the wait.
  task automatic applyStimulus(input logic [31:0] ins, input int wb_at, input logic [4:0] wa,
                               input logic [31:0] wd);
    int n;
    bit done;
    n           = 0;
    done        = 1'b0;
    instr       = ins;
    instr_valid = 1'b1;
    while (!done && n < 20) begin
      if (n == wb_at) begin
        wb_en   = 1'b1;
        wb_addr = wa;
        wb_data = wd;
      end
      tick();
      done = last_fire;
      n++;
    end
    checkOutput("issued", 32'(done), 32'd1);
    instr_valid = 1'b0;
  endtask

  task automatic apply_wb(input logic [4:0] wa, input logic [31:0] wd);
    instr_valid = 1'b0;
    wb_en       = 1'b1;
    wb_addr     = wa;
    wb_data     = wd;
    tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_pend      = '0;
    m_valid     = 1'b0;
    reset_seen  = 1'b0;
    rst         = 1'b1;
    ready       = 1'b1;
    instr_valid = 1'b1;
    instr       = mk(4'(FUNC_ADD), 5'd5, 5'd3, 5'd4, 6'd1);
    wb_en       = 1'b0;
    wb_addr     = '0;
    wb_data     = '0;

    tick();
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'hDEAD_BEEF;
    tick();
    tick();
    rst         = 1'b0;
    instr_valid = 1'b0;
    tick();

    for (int r = 1; r < 32; r++) begin
      applyStimulus(mk(4'(FUNC_ADD), 5'd0, 5'(r), 5'(31 - r), 6'(r)), -1, 5'd0, 32'd0);
    end
    tick();

    apply_wb(5'd3, 32'h0000_0010);
    applyStimulus(mk(4'(FUNC_ADD), 5'd5, 5'd3, 5'd0, 6'd0), -1, 5'd0, 32'd0);
    tick();
    apply_wb(5'd5, 32'h0000_0001);
    applyStimulus(mk(4'(FUNC_ADDI), 5'd5, 5'd3, 5'd5, 6'h3F), -1, 5'd0, 32'd0);
    applyStimulus(mk(4'(FUNC_ADD), 5'd6, 5'd5, 5'd3, 6'd2), 2, 5'd5, 32'h0000_0007);
    tick();
    apply_wb(5'd6, 32'h0000_0066);

    ready = 1'b0;
    applyStimulus(mk(4'(FUNC_OR), 5'd8, 5'd3, 5'd5, 6'd4), -1, 5'd0, 32'd0);
    instr       = mk(4'(FUNC_XOR), 5'd9, 5'd6, 5'd3, 6'd5);
    instr_valid = 1'b1;
    repeat (3) tick();
    ready = 1'b1;
    applyStimulus(instr, -1, 5'd0, 32'd0);
    applyStimulus(mk(4'(FUNC_AND), 5'd10, 5'd5, 5'd6, 6'd6), -1, 5'd0, 32'd0);
    tick();
    apply_wb(5'd8, 32'h8);
    apply_wb(5'd9, 32'h9);
    apply_wb(5'd10, 32'hA);

    apply_wb(5'd0, 32'hFFFF_FFFF);
    applyStimulus(mk(4'(FUNC_ADD), 5'd11, 5'd0, 5'd0, 6'd7), -1, 5'd0, 32'd0);
    tick();
    apply_wb(5'd11, 32'hB);

    applyStimulus(mk(4'(FUNC_SUB), 5'd7, 5'd1, 5'd2, 6'd8), -1, 5'd0, 32'd0);
    applyStimulus(mk(4'(FUNC_SUB), 5'd7, 5'd3, 5'd4, 6'd9), 2, 5'd7, 32'h0000_0055);
    tick();
    apply_wb(5'd7, 32'h0000_0077);

    for (int c = 0; c < 200; c++) begin
      instr_valid = 1'($urandom);
      instr       = mk(4'($urandom_range(0, 7)), 5'($urandom), 5'($urandom), 5'($urandom), 6'($urandom));
      ready       = ($urandom_range(0, 3) != 0);
      wb_en       = 1'($urandom);
      wb_addr     = 5'($urandom);
      wb_data     = $urandom;
      tick();
    end

    rst         = 1'b1;
    instr_valid = 1'b1;
    repeat (2) tick();
    rst         = 1'b0;
    instr_valid = 1'b0;
    ready       = 1'b1;
    applyStimulus(mk(4'(FUNC_ADD), 5'd12, 5'd3, 5'd7, 6'd1), -1, 5'd0, 32'd0);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end

endmodule
